// File: rtl/imem_loader.sv
// Boot loader: receives a big-endian byte stream (16-bit word count, then words) and writes IMEM from address 0.
// Holds the CPU in reset until the load completes, and flags the first word with an opcode the control unit lacks.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  bad_op,
   output logic [ADDR_WIDTH-1:0] bad_op_addr
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
   } state_t;

   // Counts are kept 17 bits wide so a full 2**ADDR_WIDTH load compares cleanly.
   localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

   state_t      state;
   logic [7:0]  cnt_hi;
   logic [15:0] count;
   logic [16:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic        xfer;
   logic [15:0] len_full;

   assign xfer     = in_valid & in_ready;
   assign len_full = {cnt_hi, in_data};

   function automatic logic op_supported(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         cpu_hold    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         bad_op      <= 1'b0;
         bad_op_addr <= '0;
         cnt_hi      <= '0;
         count       <= '0;
         word_idx    <= '0;
         byte_cnt    <= '0;
         shift       <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  done        <= 1'b0;
                  error       <= 1'b0;
                  bad_op      <= 1'b0;
                  bad_op_addr <= '0;
                  byte_cnt    <= '0;
                  word_idx    <= '0;
                  busy        <= 1'b1;
                  cpu_hold    <= 1'b1;
                  in_ready    <= 1'b1;
                  state       <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  cnt_hi <= in_data;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  count <= len_full;
                  if (len_full == 16'd0) begin
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= DONE;
                  end else if ({1'b0, len_full} > MAX_WORDS) begin
                     error    <= 1'b1;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= ERROR;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {shift[15:0], in_data};
                  if (byte_cnt == 2'd3) begin
                     in_ready   <= 1'b0;
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                     imem_wdata <= {shift, in_data};
                     state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               imem_we  <= 1'b0;
               word_idx <= word_idx + 17'd1;
               // Unsupported opcodes are reported, not fatal: the word is already on the bus.
               if (!op_supported(imem_wdata[31:26])) begin
                  bad_op <= 1'b1;
                  if (!bad_op) bad_op_addr <= imem_addr;
               end
               if (word_idx + 17'd1 == {1'b0, count}) begin
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  state    <= DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= DATA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the CPU control unit decodes from.
- Accepts a byte stream over a valid/ready handshake: 16-bit word count, then the instruction words, all big-endian.
- Assembles 32-bit instruction words and writes them to consecutive IMEM word addresses starting at 0.
- Holds the CPU in reset until the load completes, and flags any word whose opcode the control unit does not support.

Parameters:
ADDR_WIDTH, 8, IMEM word-address width; maximum load is 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load; ignored while busy
in_data  input  8  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
imem_we  output  1  IMEM write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  IMEM word address
imem_wdata  output  32  instruction word
cpu_hold  output  1  1 = keep the CPU in reset
busy  output  1  a load is in progress
done  output  1  load completed successfully (sticky)
error  output  1  length error (sticky)
bad_op  output  1  at least one word had an unsupported opcode (sticky)
bad_op_addr  output  ADDR_WIDTH  address of the first unsupported-opcode word

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, bad_op=0, bad_op_addr=0.
- Reset mid-load aborts immediately and returns to the reset values. Words already written to IMEM are not touched.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR, on start:
  - clear done, error, bad_op, bad_op_addr and the byte/word counters;
  - set busy=1 and cpu_hold=1;
  - go to LEN_HI with in_ready=1 from the next cycle.
- LEN_HI: on transfer, capture count[15:8] and go to LEN_LO.
- LEN_LO: on transfer, capture count[7:0], then branch on the full count:
  - count==0 -> DONE;
  - count > 2**ADDR_WIDTH -> ERROR;
  - otherwise -> DATA.
- DATA:
  - Bytes are shifted in MSB first; byte 0 becomes bits [31:24].
  - The 4th byte transfer moves to WRITE.
  - in_ready=0 while in WRITE; a byte offered then is held by the source and not lost.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=word index, imem_wdata=assembled word.
  - Then the word index increments.
  - If words written == count -> DONE, else -> DATA with in_ready=1 again.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 write cycle).
- The first byte of the next word can transfer on the cycle right after WRITE.
- Opcode check, during WRITE, on wdata[31:26]:
  - Supported opcodes: 0x00, 0x02, 0x04, 0x08, 0x0C, 0x0D, 0x0E, 0x23, 0x2B.
  - Any other opcode sets bad_op.
  - bad_op_addr is captured only if bad_op was previously 0, so it records the first offender.
  - The word is still written and loading continues; this is not an error.
- DONE: done=1, busy=0, cpu_hold=0, in_ready=0. Stays here until start or rst.
- ERROR: error=1, busy=0, cpu_hold=1, in_ready=0. Stays here until start or rst.
- start while busy (LEN_HI..WRITE) is ignored, and the load is unaffected.
- start in DONE restarts a load; cpu_hold rises the next cycle.
- in_valid with in_ready=0 has no effect.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Address wrap: with count = 2**ADDR_WIDTH, the last word goes to the maximum address. The index never wraps within one load.

Test Plan:
1. rst, start, stream 00 02 | 20 08 00 05 | 00 00 00 00 -> two write pulses: (addr 0, 0x20080005), (addr 1, 0x00000000); done=1, cpu_hold=0, bad_op=0, error=0.
2. Same load with in_valid toggling 1/0 every cycle -> identical writes, no byte lost or duplicated; in_ready=0 during each WRITE cycle.
3. Stream 00 03 | 8C 01 00 00 | FC 00 00 00 | 44 00 00 00 (opcodes 0x23, 0x3F, 0x11) -> all 3 words written; bad_op=1, bad_op_addr=1; done=1.
4. Length 0x0101 with ADDR_WIDTH=8 -> ERROR after LEN_LO, error=1, cpu_hold=1, no imem_we; then start plus a valid stream -> done=1, error=0.
5. Length 00 00 -> DONE without writes. Also: pulse start mid-load -> ignored. Also: assert rst after 2 of 3 words -> all outputs at reset values the next cycle, cpu_hold=1.
6. Max load, count 0x0100 -> last write at addr 0xFF; done=1.
